// File: rtl/serial_full_subtractor.sv
// serial_full_subtractor: bit-serial A - B - Bin, LSB first, through one full-subtractor cell.
// Optional feature macro SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf.
`timescale 1ns/1ps
module serial_full_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] res_sr_q, res_sr_d;
    logic             r_q, r_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             x;
    logic             y;
    logic             d;
    logic             r_next;
    logic [WIDTH-1:0] res_full;

    // Full-subtractor cell; res_full is the result register after this bit lands in the MSB.
    always_comb begin
        x        = a_sr_q[0];
        y        = b_sr_q[0];
        d        = x ^ y ^ r_q;
        r_next   = (~x & y) | (~(x ^ y) & r_q);
        res_full = {d, res_sr_q};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        r_d      = r_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    r_d      = bin;
                    cnt_d    = '0;
                    res_sr_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                r_d      = r_next;
                res_sr_d = res_full[WIDTH-1:1];
                cnt_d    = cnt_q + CNT_W'(1);
                // Outputs only update on the last bit so they hold across the next operation.
                if (cnt_q == CNT_LAST) begin
                    diff_d  = res_full;
                    bout_d  = r_next;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = r_q ^ r_next;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            r_q      <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            r_q      <= r_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Testbench for serial_full_subtractor (WIDTH=8): scoreboard of {bout,diff[,ovf]} plus per-scenario checks.
// Build with SERIAL_SUB_OVF_EN defined to also exercise the ovf output.
`timescale 1ns/1ps
module tb_serial_full_subtractor;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   errors    = 0;
    int   checks    = 0;
    int   done_seen = 0;
    exp_t sb[$];
    exp_t mon_e;

    serial_full_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: wide unsigned subtraction for {bout,diff}, integer range test for signed overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        exp_t       e;
        logic [W:0] t;
        int         s;
        t      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        e.diff = t[W-1:0];
        e.bout = t[W];
        s      = int'($signed(x)) - int'($signed(y)) - int'(bi);
        e.ovf  = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
        return e;
    endfunction

    // Scoreboard: push on the cycle before an accepting edge, pop/compare while done is high.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                done_seen++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done: got done=1 expected no pending result");
                end else begin
                    mon_e = sb.pop_front();
`ifdef SERIAL_SUB_OVF_EN
                    if ({bout, diff, ovf} !== {mon_e.bout, mon_e.diff, mon_e.ovf}) begin
                        errors++;
                        $display("FAIL sb_result: got bout=%b diff=%h ovf=%b expected bout=%b diff=%h ovf=%b",
                                 bout, diff, ovf, mon_e.bout, mon_e.diff, mon_e.ovf);
                    end
`else
                    if ({bout, diff} !== {mon_e.bout, mon_e.diff}) begin
                        errors++;
                        $display("FAIL sb_result: got bout=%b diff=%h expected bout=%b diff=%h",
                                 bout, diff, mon_e.bout, mon_e.diff);
                    end
`endif
                end
            end
            if (start === 1'b1 && busy === 1'b0)
                sb.push_back(model(a, b, bin));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation with a single-cycle start; returns in IDLE, WIDTH+2 edges later.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        a     = x;
        b     = y;
        bin   = bi;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (W + 1) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (diff !== '0)   begin errors++; $display("FAIL reset_diff: got %h expected 00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        a     = 8'h05;
        b     = 8'h03;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= int'(W); i++) begin
            @(negedge clk);
            checks++;
            if (done !== (i == int'(W))) begin
                errors++;
                $display("FAIL basic_done_timing: cycle %0d got done=%b expected %b", i + 1, done, i == int'(W));
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_busy: cycle %0d got %b expected 1", i + 1, busy);
            end
            tick();
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
        checks++; if (diff !== 8'h02) begin errors++; $display("FAIL basic_diff_hold: got %h expected 02", diff); end
        checks++; if (bout !== 1'b0)  begin errors++; $display("FAIL basic_bout_hold: got %b expected 0", bout); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_sb_drain: got %0d pending expected 0", sb.size()); end
        tick();
    endtask

    task automatic test_underflow();
        int d0;
        d0 = done_seen;
        run_op(8'h03, 8'h05, 1'b0);
        checks++; if (diff !== 8'hFE) begin errors++; $display("FAIL uflow_diff: got %h expected fe", diff); end
        checks++; if (bout !== 1'b1)  begin errors++; $display("FAIL uflow_bout: got %b expected 1", bout); end
        run_op(8'h00, 8'h00, 1'b1);
        // Inputs change while idle with start low: outputs must hold.
        a = 8'h55;
        b = 8'h0F;
        bin = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (diff !== 8'hFF) begin errors++; $display("FAIL bin_diff_hold: got %h expected ff", diff); end
        checks++; if (bout !== 1'b1)  begin errors++; $display("FAIL bin_bout_hold: got %b expected 1", bout); end
        checks++; if (done_seen - d0 != 2) begin errors++; $display("FAIL uflow_done_count: got %0d expected 2", done_seen - d0); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL uflow_sb_drain: got %0d pending expected 0", sb.size()); end
        tick();
    endtask

    task automatic test_start_while_busy();
        int d0;
        d0    = done_seen;
        a     = 8'h40;
        b     = 8'h11;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= int'(W) + 1; c++) begin
            if (c == 3 || c == 6) begin
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL ignore_busy: cycle %0d got %b expected 1", c, busy);
            end
            tick();
        end
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL ignore_idle: got busy=%b expected 0", busy); end
        checks++; if (diff !== 8'h2F) begin errors++; $display("FAIL ignore_diff: got %h expected 2f", diff); end
        checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_seen - d0); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ignore_sb_drain: got %0d pending expected 0", sb.size()); end
        tick();
    endtask

    task automatic test_reset_mid();
        int d0;
        a     = 8'hA5;
        b     = 8'h3C;
        bin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (diff !== '0)   begin errors++; $display("FAIL midrst_diff: got %h expected 00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst_bout: got %b expected 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL midrst_ovf: got %b expected 0", ovf); end
`endif
        sb.delete();
        d0 = done_seen;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (W + 2) tick();
        checks++; if (done_seen != d0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_seen - d0); end
        run_op(8'h9C, 8'h27, 1'b0);
        checks++; if (diff !== 8'h75) begin errors++; $display("FAIL midrst_after_diff: got %h expected 75", diff); end
        checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL midrst_after_count: got %0d expected 1", done_seen - d0); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL midrst_sb_drain: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vi [3];
        int           dcyc [3];
        int           nd;
        int           k;
        logic         idle_prev;
        va = '{8'h12, 8'h00, 8'hC8};
        vb = '{8'h34, 8'hFF, 8'h64};
        vi = '{1'b1, 1'b0, 1'b1};
        dcyc = '{0, 0, 0};
        nd = 0;
        k  = 0;
        a = va[0]; b = vb[0]; bin = vi[0];
        start = 1'b1;
        for (int t = 0; t < 60 && nd < 3; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc[nd] = t;
                nd++;
            end
            idle_prev = (busy === 1'b0);
            tick();
            if (idle_prev && k < 2) begin
                k++;
                a = va[k]; b = vb[k]; bin = vi[k];
            end
            if (nd == 3) start = 1'b0;
        end
        start = 1'b0;
        checks++; if (nd != 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", nd); end
        checks++; if (dcyc[1] - dcyc[0] != int'(W) + 2) begin errors++; $display("FAIL b2b_period1: got %0d expected %0d", dcyc[1] - dcyc[0], W + 2); end
        checks++; if (dcyc[2] - dcyc[1] != int'(W) + 2) begin errors++; $display("FAIL b2b_period2: got %0d expected %0d", dcyc[2] - dcyc[1], W + 2); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_sb_drain: got %0d pending expected 0", sb.size()); end
        repeat (2) tick();
    endtask

    task automatic test_random();
        int d0;
        d0 = done_seen;
        for (int n = 0; n < 1000; n++)
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        checks++; if (done_seen - d0 != 1000) begin errors++; $display("FAIL rand_done_count: got %0d expected 1000", done_seen - d0); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_sb_drain: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_overflow();
        run_op(8'h80, 8'h01, 1'b0);
        checks++; if (diff !== 8'h7F) begin errors++; $display("FAIL ovf1_diff: got %h expected 7f", diff); end
        checks++; if (bout !== 1'b0)  begin errors++; $display("FAIL ovf1_bout: got %b expected 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf !== 1'b1)   begin errors++; $display("FAIL ovf1_ovf: got %b expected 1", ovf); end
`endif
        run_op(8'h7F, 8'hFF, 1'b0);
        checks++; if (diff !== 8'h80) begin errors++; $display("FAIL ovf2_diff: got %h expected 80", diff); end
        checks++; if (bout !== 1'b1)  begin errors++; $display("FAIL ovf2_bout: got %b expected 1", bout); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf !== 1'b1)   begin errors++; $display("FAIL ovf2_ovf: got %b expected 1", ovf); end
`endif
        run_op(8'h10, 8'h01, 1'b0);
        checks++; if (diff !== 8'h0F) begin errors++; $display("FAIL ovf3_diff: got %h expected 0f", diff); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL ovf3_ovf: got %b expected 0", ovf); end
`endif
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ovf_sb_drain: got %0d pending expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
